// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the CPU (port 0)
// and the loader/debug port (port 1), with a watchdog that aborts unacknowledged accesses.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              done0,
    output logic              err0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              cpu_stall,
    output logic              timeout_flag
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            nextState;
    logic              lastGrant;
    logic              owner;
    logic              latWe;
    logic [ADDR_W-1:0] latAddr;
    logic [DATA_W-1:0] latWdata;
    logic [DATA_W-1:0] rdataReg0;
    logic [DATA_W-1:0] rdataReg1;
    logic [CNT_W-1:0]  watchdog;
    logic              abortFlag;
    logic              timeoutFlag;
    logic              grantValid;
    logic              grantPort;
    logic              timeoutHit;

    always_comb begin
        grantValid = req0 | req1;
        // Under contention the port that did not win last time gets the grant.
        grantPort  = (req0 && req1) ? ~lastGrant : req1;
        timeoutHit = (watchdog == CNT_W'(TIMEOUT - 1));
        nextState  = state;
        case (state)
            IDLE:    if (grantValid) nextState = ACCESS;
            ACCESS:  if (mem_ready || timeoutHit) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lastGrant   <= 1'b1;
            owner       <= 1'b0;
            latWe       <= 1'b0;
            latAddr     <= '0;
            latWdata    <= '0;
            rdataReg0   <= '0;
            rdataReg1   <= '0;
            watchdog    <= '0;
            abortFlag   <= 1'b0;
            timeoutFlag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantValid) begin
                        owner     <= grantPort;
                        lastGrant <= grantPort;
                        latWe     <= grantPort ? we1 : we0;
                        latAddr   <= grantPort ? addr1 : addr0;
                        latWdata  <= grantPort ? wdata1 : wdata0;
                        watchdog  <= '0;
                    end
                end
                ACCESS: begin
                    // Ready on the final watchdog cycle still counts as a normal completion.
                    if (mem_ready) begin
                        if (!latWe) begin
                            if (owner) rdataReg1 <= mem_rdata;
                            else       rdataReg0 <= mem_rdata;
                        end
                    end else if (timeoutHit) begin
                        abortFlag   <= 1'b1;
                        timeoutFlag <= 1'b1;
                        if (owner) rdataReg1 <= '0;
                        else       rdataReg0 <= '0;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                RESP:    abortFlag <= 1'b0;
                default: abortFlag <= 1'b0;
            endcase
        end
    end

    assign mem_req      = (state == ACCESS);
    assign mem_we       = mem_req & latWe;
    assign mem_addr     = latAddr;
    assign mem_wdata    = latWdata;
    assign done0        = (state == RESP) & ~owner;
    assign done1        = (state == RESP) & owner;
    assign err0         = done0 & abortFlag;
    assign err1         = done1 & abortFlag;
    assign rdata0       = rdataReg0;
    assign rdata1       = rdataReg1;
    assign cpu_stall    = req0 & ~done0;
    assign timeout_flag = timeoutFlag;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus contention and reset sequences,
// completions checked against a queue of expected results.
module tb_mem_port_arbiter;

    localparam int TO    = 4;
    localparam int NEVER = 99;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        done0, err0, done1, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_req, mem_we, mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic        cpu_stall, timeout_flag;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .done0(done0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .done1(done1), .err1(err1), .rdata1(rdata1),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .cpu_stall(cpu_stall), .timeout_flag(timeout_flag)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] memData;
    } vec_t;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mRd[2];
    bit          mTo;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushExp(input int port, input bit we, input int delay, input logic [31:0] memData);
        exp_t e;
        e.err = (delay >= TO);
        if (e.err) begin
            mRd[port] = '0;
            mTo = 1'b1;
        end else if (!we) begin
            mRd[port] = memData;
        end
        e.port = port;
        e.rd0  = mRd[0];
        e.rd1  = mRd[1];
        sb.push_back(e);
    endtask

    task automatic setReq(input int port, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
        if (port == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else           begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    // Scoreboard: every done pulse consumes one expected completion.
    always @(negedge clock) begin
        if (reset && (done0 || done1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {62'b0, done1, done0}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_exclusive", done0 & done1, 0);
                chk("done_port", done1 ? 1 : 0, e.port);
                chk("err_owner", e.port ? err1 : err0, e.err);
                chk("err_other", e.port ? err0 : err1, 0);
                chk("rdata0", rdata0, e.rd0);
                chk("rdata1", rdata1, e.rd1);
                if (done0) chk("cpu_stall_at_done", cpu_stall, 0);
            end
        end
    end

    task automatic runAccess(input vec_t v);
        int acc = 0;
        int n = 0;
        int accExp;
        bit gotDone = 0;
        accExp = (v.delay >= TO) ? TO : v.delay + 1;
        pushExp(v.port, v.we, v.delay, v.memData);
        @(posedge clock); #1;
        setReq(v.port, 1'b1, v.we, v.addr, v.wdata);
        while (!gotDone && n < 40) begin
            @(negedge clock);
            n++;
            mem_ready = 1'b0;
            mem_rdata = 32'hFFFF_FFFF;
            gotDone = (v.port == 1) ? done1 : done0;
            if (mem_req) begin
                chk("mem_addr", mem_addr, v.addr);
                chk("mem_we", mem_we, v.we);
                if (v.we) chk("mem_wdata", mem_wdata, v.wdata);
                if (acc == v.delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = v.memData;
                end
                acc++;
            end
            if (v.port == 0 && !gotDone) chk("cpu_stall", cpu_stall, 1);
        end
        chk("done_seen", gotDone, 1);
        chk("access_cycles", acc, accExp);
        chk("latency", n, accExp + 2);
        chk("timeout_flag", timeout_flag, mTo);
        @(posedge clock); #1;
        setReq(v.port, 1'b0, 1'b0, '0, '0);
    endtask

    // Both ports request reads continuously; grants must alternate starting at firstPort.
    task automatic contend(input int nAcc, input int firstPort);
        int k = 0;
        int dones = 0;
        for (int i = 0; i < nAcc; i++)
            pushExp((firstPort + i) % 2, 1'b0, 0, 32'h100 + i);
        @(posedge clock); #1;
        setReq(0, 1'b1, 1'b0, 32'h100, '0);
        setReq(1, 1'b1, 1'b0, 32'h200, '0);
        for (int c = 0; c < 60 && dones < nAcc; c++) begin
            @(negedge clock);
            mem_ready = 1'b0;
            if (done0 || done1) dones++;
            if (mem_req) begin
                chk("contend_addr", mem_addr, ((firstPort + k) % 2 == 0) ? 32'h100 : 32'h200);
                mem_ready = 1'b1;
                mem_rdata = 32'h100 + k;
                k++;
            end
        end
        chk("contend_dones", dones, nAcc);
        @(posedge clock); #1;
        setReq(0, 1'b0, 1'b0, '0, '0);
        setReq(1, 1'b0, 1'b0, '0, '0);
        mem_ready = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{0, 1'b0, 32'h10, 32'h0,        0,     32'hDEADBEEF};
        vecs[1] = '{1, 1'b1, 32'h40, 32'h12345678, 3,     32'hCAFE0000};
        vecs[2] = '{1, 1'b0, 32'h44, 32'h0,        1,     32'hA5A50001};
        vecs[3] = '{0, 1'b1, 32'h20, 32'h55AA55AA, 2,     32'h77777777};
        vecs[4] = '{0, 1'b0, 32'h24, 32'h0,        TO-1,  32'h0BADF00D};
        vecs[5] = '{0, 1'b0, 32'h28, 32'h0,        NEVER, 32'h0};
        vecs[6] = '{1, 1'b0, 32'h48, 32'h0,        0,     32'h13579BDF};
        mRd[0] = '0;
        mRd[1] = '0;
        mTo = 1'b0;

        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_done", {done1, done0, err1, err0}, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_timeout", timeout_flag, 0);
        @(negedge clock);
        reset = 1'b1;

        contend(4, 0);
        for (int i = 0; i < 7; i++) runAccess(vecs[i]);

        // Kill a CPU access mid-flight; lastGrant is 0 here, so reset must restore it.
        @(posedge clock); #1;
        setReq(0, 1'b1, 1'b0, 32'h80, '0);
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clock);
        chk("kill_started", mem_req, 1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("kill_mem_req", mem_req, 0);
        chk("kill_done", {done1, done0}, 0);
        chk("kill_timeout", timeout_flag, 0);
        chk("kill_rdata1", rdata1, 0);
        sb.delete();
        mRd[0] = '0;
        mRd[1] = '0;
        mTo = 1'b0;
        setReq(0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("kill_hold", {mem_req, done0, done1}, 0);
        reset = 1'b1;
        contend(2, 0);
        repeat (3) @(negedge clock);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
